// File: rtl/nibble_mem_responder.sv
// Target-side endpoint of the 4-bit nibble memory link: rebuilds word requests,
// issues them on a single-outstanding req/gnt/rvalid port and streams read data back.
module nibble_mem_responder #(
    parameter int AddrWidth  = 8,
    parameter bit StrictStrb = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [3:0]           req_data_i,
    input  logic                 req_strb_i,
    input  logic [7:0]           req_addr_i,
    input  logic                 req_write_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [3:0]           rsp_data_o,
    output logic                 rsp_last_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        IDLE, COLLECT, MEM_REQ, MEM_WAIT, RSP, COMMIT
    } state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [7:0]  addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [7:0]  strb_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        burst_err;

    function automatic logic [3:0] be_from_strb(input logic [7:0] s);
        return {s[6], s[4], s[2], s[0]};
    endfunction

    assign req_ready_o = ~rst_i & ((state_q == IDLE) | (state_q == COLLECT));
    assign accept      = req_valid_i & req_ready_o;

    // Odd beats close a byte: their strobe must match the even beat before them.
    assign burst_err = (req_addr_i != addr_q) | ~req_write_i |
                       (cnt_q[0] & (req_strb_i != strb_q[{cnt_q[2:1], 1'b0}]));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 8'h00;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            strb_q  <= 8'h00;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr_i;
                        we_q   <= req_write_i;
                        if (req_write_i) begin
                            wdata_q <= {28'h0, req_data_i};
                            strb_q  <= {7'h00, req_strb_i};
                            cnt_q   <= 3'd1;
                            state_q <= COLLECT;
                        end else begin
                            wdata_q <= 32'h0;
                            strb_q  <= 8'h00;
                            state_q <= MEM_REQ;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        wdata_q[{cnt_q, 2'b00} +: 4] <= req_data_i;
                        strb_q[cnt_q]                <= req_strb_i;
                        cnt_q                        <= cnt_q + 3'd1;
                        if (StrictStrb && burst_err) err_q <= 1'b1;
                        if (cnt_q == 3'd7) state_q <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_gnt_i) state_q <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (mem_rvalid_i) begin
                        if (we_q) begin
                            state_q <= IDLE;
                        end else begin
                            rdata_q <= mem_rdata_i;
                            cnt_q   <= 3'd0;
                            state_q <= RSP;
                        end
                    end
                end
                RSP: begin
                    // Shift so the next nibble always sits in the top four bits.
                    if (rsp_ready_i) begin
                        rdata_q <= {rdata_q[27:0], 4'h0};
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_q <= COMMIT;
                    end
                end
                COMMIT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = (state_q == MEM_REQ);
    assign mem_we_o    = mem_req_o & we_q;
    assign mem_addr_o  = mem_req_o ? AddrWidth'(addr_q) : '0;
    assign mem_wdata_o = (mem_req_o & we_q) ? wdata_q : 32'h0;
    assign mem_be_o    = mem_req_o ? (we_q ? be_from_strb(strb_q) : 4'hF) : 4'h0;

    assign rsp_valid_o = (state_q == RSP) | (state_q == COMMIT);
    assign rsp_data_o  = (state_q == RSP) ? rdata_q[31:28] : 4'h0;
    assign rsp_last_o  = (state_q == RSP) & (cnt_q == 3'd7);
    assign err_o       = err_q;

endmodule

// File: tb/tb_nibble_mem_responder.sv
// Directed bench for nibble_mem_responder: reads, writes, strobes, backpressure, reset.
module tb_nibble_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_strb, req_write;
    logic [3:0]  req_data;
    logic [7:0]  req_addr;
    logic        rsp_valid, rsp_ready, rsp_last;
    logic [3:0]  rsp_data;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int tests = 0;
    int fails = 0;

    nibble_mem_responder #(.AddrWidth(8), .StrictStrb(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .req_strb_i(req_strb), .req_addr_i(req_addr), .req_write_i(req_write),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_last_o(rsp_last),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_read(input logic [7:0] addr, input logic [31:0] data,
                            input int gnt_wait, input bit toggle, input bit hold);
        int k;
        int cyc;
        logic [3:0] exp_nib;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_data = 4'h0; req_strb = 1'b0;
        step();
        if (!hold) req_valid = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== addr || mem_we !== 1'b0 ||
            mem_be !== 4'hF || mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL rd_memreq: req=%b addr=%h we=%b be=%h wd=%h, want 1 %h 0 F 0",
                     mem_req, mem_addr, mem_we, mem_be, mem_wdata, addr);
        end
        tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 4'h0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL rd_idle_rsp: rsp_valid=%b rsp_data=%h req_ready=%b, want 0 0 0",
                     rsp_valid, rsp_data, req_ready);
        end
        for (int i = 0; i < gnt_wait; i++) begin
            step();
            tests++;
            if (mem_req !== 1'b1 || mem_addr !== addr || mem_be !== 4'hF || mem_we !== 1'b0) begin
                fails++;
                $display("FAIL rd_gnt_stall: req=%b addr=%h be=%h we=%b, want 1 %h F 0",
                         mem_req, mem_addr, mem_be, mem_we, addr);
            end
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL rd_req_drop: mem_req=%b, want 0", mem_req);
        end
        mem_rvalid = 1'b1; mem_rdata = data;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 40) begin
            rsp_ready = toggle ? cyc[0] : 1'b1;
            exp_nib = data[(31 - 4*k) -: 4];
            tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_nib || rsp_last !== (k == 7) ||
                req_ready !== 1'b0) begin
                fails++;
                $display("FAIL rd_beat%0d: valid=%b data=%h last=%b ready=%b, want 1 %h %b 0",
                         k, rsp_valid, rsp_data, rsp_last, req_ready, exp_nib, (k == 7));
            end
            if (rsp_ready) k++;
            cyc++;
            step();
        end
        rsp_ready = 1'b0;
        tests++;
        if (k != 8) begin
            fails++;
            $display("FAIL rd_beat_count: got %0d beats, want 8", k);
        end
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'h0 || rsp_last !== 1'b0 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL rd_commit: valid=%b data=%h last=%b ready=%b, want 1 0 0 0",
                     rsp_valid, rsp_data, rsp_last, req_ready);
        end
        step();
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL rd_back_idle: rsp_valid=%b req_ready=%b mem_req=%b, want 0 1 0",
                     rsp_valid, req_ready, mem_req);
        end
    endtask

    task automatic run_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [7:0] strb, input logic [3:0] exp_be,
                             input logic exp_err);
        for (int b = 0; b < 8; b++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
            req_data = data[4*b +: 4]; req_strb = strb[b];
            tests++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
                fails++;
                $display("FAIL wr_beat%0d: ready=%b rsp_valid=%b mem_req=%b, want 1 0 0",
                         b, req_ready, rsp_valid, mem_req);
            end
            step();
        end
        req_valid = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== addr ||
            mem_wdata !== data || mem_be !== exp_be) begin
            fails++;
            $display("FAIL wr_memreq: req=%b we=%b addr=%h wd=%h be=%b, want 1 1 %h %h %b",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be, addr, data, exp_be);
        end
        tests++;
        if (err !== exp_err || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL wr_err: err=%b req_ready=%b, want %b 0", err, req_ready, exp_err);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL wr_done: ready=%b rsp_valid=%b mem_req=%b, want 1 0 0",
                     req_ready, rsp_valid, mem_req);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_data = 4'h0; req_strb = 1'b0;
        rsp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step(); step();
        tests++;
        if (req_ready !== 1'b0 || mem_req !== 1'b0 || rsp_valid !== 1'b0 || err !== 1'b0 ||
            mem_be !== 4'h0 || rsp_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b mem_req=%b rsp_valid=%b err=%b be=%h last=%b",
                     req_ready, mem_req, rsp_valid, err, mem_be, rsp_last);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: req_ready=%b, want 1", req_ready);
        end
        step();
    endtask

    task automatic test_read;
        run_read(8'h3C, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    endtask

    task automatic test_write;
        run_write(8'h05, 32'h12345678, 8'hFF, 4'hF, 1'b0);
    endtask

    task automatic test_strobe;
        run_write(8'h21, 32'hA5A5C3C3, 8'hCC, 4'b1010, 1'b0);
    endtask

    task automatic test_backpressure;
        run_read(8'h81, 32'h13579BDF, 5, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_read(8'h40, 32'h89ABCDEF, 1, 1'b0, 1'b1);
        run_read(8'h41, 32'h76543210, 0, 1'b0, 1'b0);
    endtask

    task automatic test_strobe_error;
        run_write(8'h10, 32'hCAFEF00D, 8'hFD, 4'hF, 1'b1);
        run_read(8'h11, 32'h0BADCAFE, 0, 1'b0, 1'b0);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
    endtask

    task automatic test_reset_mid_burst;
        for (int b = 0; b < 4; b++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h77;
            req_data = 4'h9; req_strb = 1'b1;
            step();
        end
        rst = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_burst: ready=%b err=%b mem_req=%b, want 0 0 0",
                     req_ready, err, mem_req);
        end
        step();
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
                fails++;
                $display("FAIL rst_no_access: mem_req=%b ready=%b, want 0 1", mem_req, req_ready);
            end
        end
        run_read(8'h00, 32'h0F1E2D3C, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_strobe();
        test_backpressure();
        test_back_to_back();
        test_strobe_error();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_mem_responder.md
Name: nibble_mem_responder

Overview:
- Target-side endpoint of the 4-bit nibble memory link driven by the core wrapper.
- Receives nibble-serialized requests and rebuilds a 32-bit word request: 8-bit word address, write flag, data, byte enables.
- Issues the request on a single-outstanding SRAM-style req/gnt/rvalid port.
- For reads, streams the 32-bit result back as 8 nibbles, MSB first, then drives one commit beat.
- Instantiated in the eFPGA fabric facing the chip pins.

Parameters:
AddrWidth, 8, width of mem_addr_o; link word address zero-extended (must be >= 8).
StrictStrb, 1, 1 = flag strobe/address/write inconsistencies within a write burst on err_o; 0 = ignore them.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  1  request beat valid
req_ready_o  out  1  request beat accepted when req_valid_i & req_ready_o
req_data_i  in  4  write data nibble, LSB nibble first; ignored for reads
req_strb_i  in  1  strobe of the current nibble
req_addr_i  in  8  word address, stable for the whole burst
req_write_i  in  1  1 = write burst of 8 beats, 0 = read of 1 beat
rsp_valid_o  out  1  response nibble valid
rsp_ready_i  in  1  response nibble accepted
rsp_data_o  out  4  response nibble
rsp_last_o  out  1  marks 8th response nibble
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_we_o  out  1  write enable
mem_addr_o  out  AddrWidth  word address
mem_wdata_o  out  32  write data
mem_be_o  out  4  byte enables
mem_rvalid_i  in  1  completion, exactly one per granted request (reads and writes)
mem_rdata_i  in  32  read data, valid with mem_rvalid_i
err_o  out  1  sticky protocol error; cleared only by reset

Behaviour:
- Reset (async, rst_i=1): state IDLE; beat count 0; all data registers 0; req_ready_o=0 during reset, then 1 in IDLE; all other outputs 0.
- States: IDLE, COLLECT, MEM_REQ, MEM_WAIT, RSP, COMMIT. req_ready_o=1 only in IDLE and COLLECT.
- IDLE:
  - Accepted beat with req_write_i=0: latch address; read; go MEM_REQ.
  - Accepted beat with req_write_i=1: latch address, nibble 0 into wdata[3:0] and strb bit 0; count=1; go COLLECT.
- COLLECT:
  - Beat k (1..7) writes wdata[4k+3:4k] and strb bit k.
  - After beat 7: count=0; go MEM_REQ.
  - Byte enable i = strb bit 2i.
  - With StrictStrb=1, set err_o on any of: strb bit 2i != strb bit 2i+1; req_addr_i change; req_write_i change during the burst.
  - An error does not abort the burst.
- MEM_REQ:
  - mem_req_o=1; mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o held stable from registers until mem_gnt_i.
  - Reads drive mem_be_o=4'hF and mem_wdata_o=0.
  - On grant: go MEM_WAIT (mem_req_o drops the next cycle).
  - A same-cycle mem_rvalid_i is not legal.
- MEM_WAIT, on mem_rvalid_i:
  - Write: go IDLE; no link response for writes.
  - Read: capture mem_rdata_i into rsp register; go RSP.
- RSP:
  - rsp_valid_o=1; beat k (0..7) drives rdata[31-4k:28-4k].
  - rsp_last_o=1 on beat 7 only; advance on rsp_valid_o & rsp_ready_i.
  - After beat 7 handshake: go COMMIT.
- COMMIT:
  - rsp_valid_o=1, rsp_last_o=0, rsp_data_o=0 for exactly one cycle, independent of rsp_ready_i; then IDLE.
  - The initiator uses this beat to deliver the assembled word.
- Latency, read: request beat at cycle 0 -> mem_req_o at cycle 1. Mem grant at cycle 1 with rvalid at cycle 2 -> first rsp nibble valid at cycle 3.
- One transaction in flight; new requests stall via req_ready_o=0 until IDLE.
- rsp_data_o and rsp_last_o are 0 whenever rsp_valid_o=0.
- Reset mid-burst or mid-response discards the transaction; no memory access is issued after reset.

Test Plan:
- Read addr 8'h3C; memory returns 32'hDEADBEEF one cycle after grant -> mem_addr_o=0x3C, mem_we_o=0, mem_be_o=F; rsp nibbles D,E,A,D,B,E,E,F; last on F; one commit cycle; then req_ready_o=1.
- Write addr 8'h05, data 32'h12345678 as nibbles 8,7,6,5,4,3,2,1, strb all 1 -> one mem request, wdata=0x12345678, be=F, we=1; no rsp_valid_o; err_o=0.
- Write with strb pattern 0,0,1,1,0,0,1,1 -> mem_be_o=4'b1010; mismatched pattern 1,0,... -> err_o=1 and stays set until rst_i.
- Backpressure: mem_gnt_i low for 5 cycles, then rsp_ready_i toggling 1/0 -> mem outputs stable while waiting; every nibble held until accepted; exactly 8 data beats.
- req_valid_i held high during a read response -> req_ready_o=0 throughout; next request accepted only after COMMIT.
- rst_i asserted at write beat 4 -> mem_req_o never asserts; after release a read of addr 0 completes normally.
